// File: rtl/cursor_move_sched.sv
// Frame-synchronous cursor mover: button pulses are serialised into a small
// command FIFO and exactly one queued move is applied per frame at vsync assertion.
module cursor_move_sched #(
  parameter int   GRID_W       = 8,
  parameter int   GRID_H       = 12,
  parameter bit   WRAP         = 1'b0,
  parameter int   FIFO_DEPTH   = 4,
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       vsync,
  output logic [2:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic       cursor_upd,
  output logic       fifo_full,
  output logic [7:0] drop_cnt
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [2:0] X_MAX    = 3'(GRID_W - 1);
  localparam logic [3:0] Y_MAX    = 4'(GRID_H - 1);
  localparam logic [1:0] CMD_UP   = 2'd0;
  localparam logic [1:0] CMD_DOWN = 2'd1;
  localparam logic [1:0] CMD_LEFT = 2'd2;
  localparam logic [1:0] CMD_RGHT = 2'd3;

  logic [3:0]  btn;
  logic [3:0]  pend_q, pend_d;
  logic [1:0]  mem_q [FIFO_DEPTH];
  logic [1:0]  mem_d [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full_q, full_d;
  logic        vsync_d_q, vsync_d_d;
  logic [2:0]  x_q, x_d;
  logic [3:0]  y_q, y_d;
  logic        upd_q, upd_d;
  logic [7:0]  drop_q, drop_d;

  logic        empty, fb, pop, push;
  logic [1:0]  sel, cmd;
  logic [3:0]  clr, drops;
  logic [2:0]  ndrop;
  logic [8:0]  drop_sum;

  assign btn = {btn_right, btn_left, btn_down, btn_up};

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    fb        = (vsync == VSYNC_ACTIVE) && (vsync_d_q != VSYNC_ACTIVE);
    // Pop is decided on the pre-push pointers, so a same-cycle push into an
    // empty FIFO waits for the next frame.
    pop       = fb && !empty;
    push      = (|pend_q) && (!full_q || pop);
    vsync_d_d = vsync;

    if (pend_q[0])      sel = CMD_UP;
    else if (pend_q[1]) sel = CMD_DOWN;
    else if (pend_q[2]) sel = CMD_LEFT;
    else                sel = CMD_RGHT;

    clr    = push ? (4'b0001 << sel) : 4'b0000;
    drops  = btn & pend_q & ~clr;
    pend_d = (pend_q & ~clr) | btn;

    ndrop    = 3'(drops[0]) + 3'(drops[1]) + 3'(drops[2]) + 3'(drops[3]);
    drop_sum = {1'b0, drop_q} + {6'b000000, ndrop};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    if (push) mem_d[wr_ptr_q[AW-1:0]] = sel;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    cmd   = mem_q[rd_ptr_q[AW-1:0]];
    x_d   = x_q;
    y_d   = y_q;
    upd_d = pop;
    if (pop) begin
      case (cmd)
        CMD_UP: begin
          if (y_q == 4'd0) y_d = WRAP ? Y_MAX : y_q;
          else             y_d = y_q - 4'd1;
        end
        CMD_DOWN: begin
          if (y_q == Y_MAX) y_d = WRAP ? 4'd0 : y_q;
          else              y_d = y_q + 4'd1;
        end
        CMD_LEFT: begin
          if (x_q == 3'd0) x_d = WRAP ? X_MAX : x_q;
          else             x_d = x_q - 3'd1;
        end
        default: begin
          if (x_q == X_MAX) x_d = WRAP ? 3'd0 : x_q;
          else              x_d = x_q + 3'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 4'b0000;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      full_q    <= 1'b0;
      vsync_d_q <= ~VSYNC_ACTIVE;
      x_q       <= 3'd0;
      y_q       <= 4'd0;
      upd_q     <= 1'b0;
      drop_q    <= 8'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 2'd0;
    end else begin
      pend_q    <= pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      full_q    <= full_d;
      vsync_d_q <= vsync_d_d;
      x_q       <= x_d;
      y_q       <= y_d;
      upd_q     <= upd_d;
      drop_q    <= drop_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign cursor_x   = x_q;
  assign cursor_y   = y_q;
  assign cursor_upd = upd_q;
  assign fifo_full  = full_q;
  assign drop_cnt   = drop_q;

endmodule

// File: doc/cursor_move_sched.md
# cursor_move_sched

Frame-synchronous scheduler for cursor movement. It sits between the four `button_pulse` outputs and the pixel generator, in the `lcd_clk_33m` domain, and replaces direct cursor updates. Button pulses are serialised by fixed priority into a small command FIFO. Exactly one queued move is applied per LCD frame, at the vsync assertion edge, so the cursor never changes mid-frame and never tears.

## Interface
Parameters:
- `GRID_W`, 8: number of cursor columns; `cursor_x` range is 0..GRID_W-1 (≤8).
- `GRID_H`, 12: number of cursor rows; `cursor_y` range is 0..GRID_H-1 (≤16).
- `WRAP`, 0: edge behaviour. 0 = clamp at the edges; 1 = wrap to the opposite edge.
- `FIFO_DEPTH`, 4: command FIFO entries; must be a power of 2, ≥2.
- `VSYNC_ACTIVE`, 1'b0: level of `vsync` during the sync pulse.

Ports:
- `clk` in 1: LCD pixel clock; every input is synchronous to it.
- `rst_n` in 1: reset, asynchronous and active-low.
- `btn_up` in 1: single-cycle move-up pulse.
- `btn_down` in 1: single-cycle move-down pulse.
- `btn_left` in 1: single-cycle move-left pulse.
- `btn_right` in 1: single-cycle move-right pulse.
- `vsync` in 1: vsync output of the LCD timing controller.
- `cursor_x` out 3: registered cursor column.
- `cursor_y` out 4: registered cursor row.
- `cursor_upd` out 1: one-cycle pulse; a queued command was applied.
- `fifo_full` out 1: command FIFO holds FIFO_DEPTH entries.
- `drop_cnt` out 8: saturating count of discarded button pulses.

## Operation
- Command encoding is 2 bits: up=0, down=1, left=2, right=3.
- Pending stage: one `pend[d]` bit per direction. A pulse sets its bit.
- Drop rule: a pulse arriving while its bit is already set is discarded and increments `drop_cnt`. The count saturates at 255.
- Push arbiter: each cycle, if any `pend` bit is set and the FIFO is not full (or a pop is occurring in the same cycle), the highest-priority pending direction is pushed and its bit is cleared. Priority order is up > down > left > right.
- Simultaneous pulses are serialised by the arbiter: one push per cycle.
- A pulse arriving in the same cycle its bit is cleared by a push re-sets the bit. It is not counted as a drop.
- Frame boundary: `vsync_d` is a registered copy of `vsync`. `fb = (vsync==VSYNC_ACTIVE) && (vsync_d!=VSYNC_ACTIVE)`.
- Apply: on a cycle with `fb` and FIFO non-empty, pop one command and update the cursor.
  - up: y-1; down: y+1; left: x-1; right: x+1.
  - Edge with WRAP=0: the coordinate is held.
  - Edge with WRAP=1: 0↔GRID_H-1 for rows, 0↔GRID_W-1 for columns.
- `cursor_upd` pulses for every pop, including clamped (no-change) moves.
- `fb` with an empty FIFO: no change, no `cursor_upd`.
- At most one pop per frame. Remaining entries wait for later frames.
- Push and pop in the same cycle are both performed. When the FIFO is full, this keeps the count unchanged.
- FIFO pointer arithmetic: log2(FIFO_DEPTH)+1-bit pointers. Full = MSBs differ and the lower bits are equal.

## Timing
- Reset values (asynchronous): `cursor_x`=0, `cursor_y`=0, `cursor_upd`=0, `fifo_full`=0, `drop_cnt`=0. `pend` is cleared, FIFO is empty, `vsync_d`=~VSYNC_ACTIVE.
- Reset asserted mid-operation flushes all queued and pending commands immediately.
- Pulse at cycle T sets `pend` at T+1. The earliest push is at T+1, so the FIFO entry is visible at T+2.
- `vsync` asserts at cycle F, so `fb` is high in cycle F. `cursor_x`/`cursor_y`/`cursor_upd` change at the F+1 clock edge. `cursor_upd` is low again at F+2.
- `fifo_full` is registered and tracks the count with the same one-cycle latency as the pointers.
- A command pushed in the same cycle as `fb` is not eligible for that frame's pop when the FIFO was empty beforehand.

## Test plan
- Reset, cursor (0,0), WRAP=0: pulse `btn_down` once, then give 3 vsync edges. Required: cursor (0,1) one cycle after the first edge, exactly one `cursor_upd`, no change on later edges.
- Simultaneous `btn_up`/`btn_down`/`btn_left`/`btn_right` in one cycle from cursor (3,5): required FIFO order up, down, left, right. Over 4 frames the cursor goes (3,4), (3,5), (2,5), (3,5), with 4 `cursor_upd` pulses.
- Overflow: with no vsync, issue 10 `btn_right` pulses spaced 2 cycles apart, FIFO_DEPTH=4. Required: `fifo_full`=1, 4 entries in the FIFO, 1 pending, `drop_cnt`=5.
- Edges with WRAP=0 at cursor (0,0): `btn_left` then `btn_up`. Required: cursor stays (0,0) and `cursor_upd` pulses twice. Repeat with WRAP=1: required (7,0) after the first frame and (7,11) after the second.
- Reset mid-operation: 3 queued moves, assert `rst_n`=0 for 1 cycle between frames. Required: cursor (0,0) and `fifo_full`=0 asynchronously, and no `cursor_upd` on the following 3 vsync edges.
